// File: rtl/omp_dict_row_streamer.sv
// omp_dict_row_streamer: fetches a wrapping run of dictionary rows and serializes each into a word stream
module omp_dict_row_streamer #(
  parameter int ADDR_W        = 5,
  parameter int ROW_W         = 1152,
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_ROW = 36,
  parameter int RD_LAT        = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_row,
  input  logic [ADDR_W:0]   num_rows,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [ROW_W-1:0]  ram_dout,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [5:0]        m_word_idx,
  output logic [ADDR_W-1:0] m_row_idx,
  output logic              m_last_word,
  output logic              m_last_row
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, FIN} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] rows_left, n_clamp;
  logic [2:0] lat_cnt;
  logic [ROW_W-1:0] row_reg;
  logic fin_hold, xfer, lat_done, row_end, final_row;
  assign n_clamp   = num_rows > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : num_rows;
  assign xfer      = state == STREAM && m_ready;
  assign lat_done  = lat_cnt == 3'(RD_LAT);
  assign row_end   = xfer && m_word_idx == 6'(WORDS_PER_ROW-1);
  assign final_row = rows_left == (ADDR_W+1)'(1);
  // state register
  always_ff @(posedge clka) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // next-state logic; a zero-row command goes straight to FIN and lingers one extra cycle there
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (start) state_n = n_clamp == '0 ? FIN : FETCH;
      FETCH, WAIT: if (lat_done) state_n = STREAM;
      STREAM:      if (row_end) state_n = final_row ? FIN : WAIT;
      FIN:         if (!fin_hold) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end
  // outputs decoded from state; the row register shifts so the current word is always its LSBs
  always_comb begin
    busy        = state == FETCH || state == WAIT || state == STREAM || (state == FIN && fin_hold);
    done        = state == FIN && !fin_hold;
    m_valid     = state == STREAM;
    m_data      = row_reg[WORD_W-1:0];
    m_last_word = state == STREAM && m_word_idx == 6'(WORDS_PER_ROW-1);
    m_last_row  = state == STREAM && final_row;
  end
  // datapath: RAM address, read-latency counter, row register and word/row indices
  always_ff @(posedge clka) begin
    if (rst) begin
      ram_addr   <= '0;
      rows_left  <= '0;
      lat_cnt    <= '0;
      row_reg    <= '0;
      m_word_idx <= '0;
      m_row_idx  <= '0;
      fin_hold   <= 1'b0;
    end else begin
      fin_hold <= state == IDLE && start && n_clamp == '0;
      if (state == IDLE && start) begin
        rows_left <= n_clamp;
        lat_cnt   <= '0;
        if (n_clamp != '0) ram_addr <= first_row;
      end
      if (state == FETCH || state == WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
        if (lat_done) begin
          row_reg    <= ram_dout;
          m_row_idx  <= ram_addr;
          m_word_idx <= '0;
        end
      end
      if (xfer) begin
        row_reg    <= row_reg >> WORD_W;
        m_word_idx <= m_word_idx + 6'd1;
        if (row_end) begin
          m_word_idx <= '0;
          rows_left  <= rows_left - (ADDR_W+1)'(1);
          lat_cnt    <= '0;
          if (!final_row) ram_addr <= ram_addr + ADDR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_omp_dict_row_streamer.sv
// tb_omp_dict_row_streamer: directed scenarios for the dictionary row streamer at read latencies 1 and 2
module tb_omp_dict_row_streamer;
  logic clka = 1'b0;
  logic rst, start, m_ready, sel;
  logic [4:0] first_row;
  logic [5:0] num_rows;
  logic busy1, done1, valid1, lw1, lr1, busy2, done2, valid2, lw2, lr2;
  logic [4:0] addr1, ridx1, addr2, ridx2, a1, a2a, a2b;
  logic [31:0] data1, data2;
  logic [5:0] widx1, widx2;
  logic [1151:0] dout1, dout2;
  logic v_busy, v_done, v_valid, v_lw, v_lr;
  logic [4:0] v_ridx;
  logic [5:0] v_widx;
  logic [31:0] v_data;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q_data[$];
  int q_widx[$], q_ridx[$], q_cyc[$];
  bit q_lw[$], q_lr[$];
  int first_v, done_c, dones, holdv;
  logic busy0, busy_done;
  bit pat[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clka = ~clka;

  omp_dict_row_streamer #(.RD_LAT(1)) dut1 (
    .clka(clka), .rst(rst), .start(start), .first_row(first_row), .num_rows(num_rows),
    .busy(busy1), .done(done1), .ram_addr(addr1), .ram_dout(dout1), .m_data(data1),
    .m_valid(valid1), .m_ready(m_ready), .m_word_idx(widx1), .m_row_idx(ridx1),
    .m_last_word(lw1), .m_last_row(lr1));

  omp_dict_row_streamer #(.RD_LAT(2)) dut2 (
    .clka(clka), .rst(rst), .start(start), .first_row(first_row), .num_rows(num_rows),
    .busy(busy2), .done(done2), .ram_addr(addr2), .ram_dout(dout2), .m_data(data2),
    .m_valid(valid2), .m_ready(m_ready), .m_word_idx(widx2), .m_row_idx(ridx2),
    .m_last_word(lw2), .m_last_row(lr2));

  function automatic logic [1151:0] row_of(input logic [4:0] r);
    logic [1151:0] d;
    d = '0;
    for (int k = 0; k < 36; k++) d[k*32 +: 32] = {16'hA5A5, 3'b000, r, 8'(k)};
    return d;
  endfunction

  always_ff @(posedge clka) begin
    a1  <= addr1;
    a2a <= addr2;
    a2b <= a2a;
  end
  assign dout1 = row_of(a1);
  assign dout2 = row_of(a2b);

  assign v_busy  = sel ? busy2  : busy1;
  assign v_done  = sel ? done2  : done1;
  assign v_valid = sel ? valid2 : valid1;
  assign v_lw    = sel ? lw2    : lw1;
  assign v_lr    = sel ? lr2    : lr1;
  assign v_ridx  = sel ? ridx2  : ridx1;
  assign v_widx  = sel ? widx2  : widx1;
  assign v_data  = sel ? data2  : data1;

  function automatic logic [31:0] exp_word(input int fr, input int i);
    logic [4:0] r;
    r = 5'((fr + i / 36) % 32);
    return {16'hA5A5, 3'b000, r, 8'(i % 36)};
  endfunction

  function automatic int stream_errs(input int fr);
    int e = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== exp_word(fr, i)) e++;
      if (q_widx[i] != i % 36) e++;
      if (q_ridx[i] != (fr + i / 36) % 32) e++;
      if (q_lw[i] != (i % 36 == 35)) e++;
    end
    return e;
  endfunction

  function automatic int last_cyc();
    return q_cyc.size() > 0 ? q_cyc[q_cyc.size()-1] : -1;
  endfunction

  task automatic issue(input logic [4:0] fr, input logic [5:0] n);
    @(posedge clka); #1;
    start = 1'b1; first_row = fr; num_rows = n;
    @(posedge clka); #1;
    start = 1'b0;
  endtask

  task automatic collect(input int maxc, input bit stall, input int inj);
    logic [45:0] pv;
    bit ps = 1'b0;
    q_data.delete(); q_widx.delete(); q_ridx.delete(); q_cyc.delete(); q_lw.delete(); q_lr.delete();
    first_v = -1; done_c = -1; dones = 0; holdv = 0; busy0 = v_busy; busy_done = 1'bx; pv = '0;
    for (int c = 0; c < maxc; c++) begin
      if (c == inj) begin start = 1'b1; first_row = 5'd0; num_rows = 6'd1; end
      else start = 1'b0;
      m_ready = stall ? pat[c % 9] : 1'b1;
      if (ps && {v_valid, v_data, v_widx, v_ridx, v_lw, v_lr} != pv) holdv++;
      if (v_valid && first_v < 0) first_v = c;
      if (v_valid && m_ready) begin
        q_data.push_back(v_data); q_widx.push_back(int'(v_widx)); q_ridx.push_back(int'(v_ridx));
        q_lw.push_back(v_lw); q_lr.push_back(v_lr); q_cyc.push_back(c);
      end
      ps = v_valid && !m_ready;
      pv = {v_valid, v_data, v_widx, v_ridx, v_lw, v_lr};
      if (v_done) begin done_c = c; busy_done = v_busy; dones++; break; end
      @(posedge clka); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; sel = 1'b0; first_row = '0; num_rows = '0;
    repeat (3) @(posedge clka);
    #1;
    n_cmp++;
    if ({busy1, done1, addr1, data1, valid1, widx1, ridx1, lw1, lr1} !== '0) begin
      n_bad++; $display("FAIL reset_outputs_lat1: got %h want 0", {busy1, done1, addr1, data1, valid1, widx1, ridx1, lw1, lr1});
    end
    n_cmp++;
    if ({busy2, done2, addr2, data2, valid2, widx2, ridx2, lw2, lr2} !== '0) begin
      n_bad++; $display("FAIL reset_outputs_lat2: got %h want 0", {busy2, done2, addr2, data2, valid2, widx2, ridx2, lw2, lr2});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int lr_n = 0;
    issue(5'd0, 6'd1);
    collect(200, 1'b0, -1);
    foreach (q_lr[i]) lr_n += int'(q_lr[i]);
    n_cmp++; if (q_data.size() != 36) begin n_bad++; $display("FAIL single_count: got %0d want 36", q_data.size()); end
    n_cmp++; if (first_v != 2) begin n_bad++; $display("FAIL single_first_valid: got %0d want 2", first_v); end
    n_cmp++; if (stream_errs(0) != 0) begin n_bad++; $display("FAIL single_data: got %0d errors want 0", stream_errs(0)); end
    n_cmp++; if (q_cyc.size() == 0 || last_cyc() - q_cyc[0] != 35) begin n_bad++; $display("FAIL single_back_to_back: got span %0d want 35", q_cyc.size() ? last_cyc() - q_cyc[0] : -1); end
    n_cmp++; if (lr_n != 36) begin n_bad++; $display("FAIL single_last_row: got %0d want 36", lr_n); end
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL single_busy_start: got %b want 1", busy0); end
    n_cmp++; if (done_c != last_cyc() + 1 || busy_done !== 1'b0) begin n_bad++; $display("FAIL single_done: got cyc %0d busy %b want cyc %0d busy 0", done_c, busy_done, last_cyc() + 1); end
  endtask

  task automatic test_wrap();
    int gap_bad = 0, lr_bad = 0;
    issue(5'd30, 6'd4);
    collect(400, 1'b0, -1);
    for (int j = 1; j < 4; j++) if (q_cyc.size() > 36*j && q_cyc[36*j] - q_cyc[36*j-1] != 3) gap_bad++;
    foreach (q_lr[i]) if (q_lr[i] != (i >= 108)) lr_bad++;
    n_cmp++; if (q_data.size() != 144) begin n_bad++; $display("FAIL wrap_count: got %0d want 144", q_data.size()); end
    n_cmp++; if (stream_errs(30) != 0) begin n_bad++; $display("FAIL wrap_data: got %0d errors want 0", stream_errs(30)); end
    n_cmp++; if (gap_bad != 0) begin n_bad++; $display("FAIL wrap_gap: got %0d bad gaps want 0", gap_bad); end
    n_cmp++; if (lr_bad != 0) begin n_bad++; $display("FAIL wrap_last_row: got %0d bad flags want 0", lr_bad); end
  endtask

  task automatic test_stall();
    issue(5'd5, 6'd1);
    collect(400, 1'b1, -1);
    m_ready = 1'b1;
    n_cmp++; if (q_data.size() != 36) begin n_bad++; $display("FAIL stall_count: got %0d want 36", q_data.size()); end
    n_cmp++; if (stream_errs(5) != 0) begin n_bad++; $display("FAIL stall_data: got %0d errors want 0", stream_errs(5)); end
    n_cmp++; if (holdv != 0) begin n_bad++; $display("FAIL stall_hold: got %0d changes while stalled want 0", holdv); end
    n_cmp++; if (last_cyc() != 108 || done_c != 109) begin n_bad++; $display("FAIL stall_timing: got last %0d done %0d want 108 109", last_cyc(), done_c); end
  endtask

  task automatic test_zero_and_clamp();
    issue(5'd9, 6'd0);
    collect(20, 1'b0, -1);
    n_cmp++; if (first_v != -1 || q_data.size() != 0) begin n_bad++; $display("FAIL zero_no_stream: got first_valid %0d count %0d want -1 0", first_v, q_data.size()); end
    n_cmp++; if (busy0 !== 1'b1 || done_c != 1 || busy_done !== 1'b0) begin n_bad++; $display("FAIL zero_handshake: got busy0 %b done %0d busy_done %b want 1 1 0", busy0, done_c, busy_done); end
    issue(5'd3, 6'd40);
    collect(2000, 1'b0, -1);
    n_cmp++; if (q_data.size() != 1152) begin n_bad++; $display("FAIL clamp_count: got %0d want 1152", q_data.size()); end
    n_cmp++; if (stream_errs(3) != 0) begin n_bad++; $display("FAIL clamp_data: got %0d errors want 0", stream_errs(3)); end
    n_cmp++; if (q_cyc.size() == 0 || last_cyc() - q_cyc[0] != 1213) begin n_bad++; $display("FAIL clamp_span: got %0d want 1213", q_cyc.size() ? last_cyc() - q_cyc[0] : -1); end
  endtask

  task automatic test_back_to_back();
    issue(5'd10, 6'd2);
    collect(400, 1'b0, 20);
    n_cmp++; if (q_data.size() != 72 || stream_errs(10) != 0) begin n_bad++; $display("FAIL ignore_start_stream: got count %0d errors %0d want 72 0", q_data.size(), stream_errs(10)); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL ignore_start_done: got %0d want 1", dones); end
    @(posedge clka); #1;
    @(posedge clka); #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL ignore_start_idle: got busy %b want 0", busy1); end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int bad = 0;
    m_ready = 1'b1;
    issue(5'd12, 6'd4);
    for (int c = 0; c < 400 && !found; c++) begin
      if (valid1 && ridx1 == 5'd14 && widx1 == 6'd10) found = 1'b1;
      else begin @(posedge clka); #1; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL abort_reach: got no word 10 of row 14 want reached"); end
    rst = 1'b1;
    @(posedge clka); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy1, done1, addr1, data1, valid1, widx1, ridx1, lw1, lr1} !== '0) begin
      n_bad++; $display("FAIL abort_outputs: got %h want 0", {busy1, done1, addr1, data1, valid1, widx1, ridx1, lw1, lr1});
    end
    for (int c = 0; c < 40; c++) begin
      bad += int'(done1) + int'(valid1) + int'(busy1);
      @(posedge clka); #1;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d activity cycles want 0", bad); end
    issue(5'd7, 6'd1);
    collect(200, 1'b0, -1);
    n_cmp++; if (q_data.size() != 36 || stream_errs(7) != 0) begin n_bad++; $display("FAIL abort_restart: got count %0d errors %0d want 36 0", q_data.size(), stream_errs(7)); end
  endtask

  task automatic test_rd_lat2();
    for (int c = 0; c < 3000 && (busy1 || busy2); c++) begin @(posedge clka); #1; end
    n_cmp++; if (busy1 || busy2) begin n_bad++; $display("FAIL lat2_drain: got busy %b%b want 00", busy1, busy2); end
    sel = 1'b1;
    issue(5'd20, 6'd2);
    collect(400, 1'b0, -1);
    n_cmp++; if (first_v != 3) begin n_bad++; $display("FAIL lat2_first_valid: got %0d want 3", first_v); end
    n_cmp++; if (q_data.size() != 72 || stream_errs(20) != 0) begin n_bad++; $display("FAIL lat2_data: got count %0d errors %0d want 72 0", q_data.size(), stream_errs(20)); end
    n_cmp++; if (q_cyc.size() < 37 || q_cyc[36] - q_cyc[35] != 4) begin n_bad++; $display("FAIL lat2_gap: got %0d want 4", q_cyc.size() >= 37 ? q_cyc[36] - q_cyc[35] : -1); end
    n_cmp++; if (done_c != last_cyc() + 1) begin n_bad++; $display("FAIL lat2_done: got %0d want %0d", done_c, last_cyc() + 1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_stall();
    test_zero_and_clamp();
    test_back_to_back();
    test_abort();
    test_rd_lat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/omp_dict_row_streamer.md
Name: omp_dict_row_streamer

Overview:
Read sequencer for the 32-row x 1152-bit dictionary RAM wrapper (single port: address in, registered data out). On a start command it fetches a contiguous, wrapping run of rows and serializes each row into 36 x 32-bit words on a valid/ready stream. This is the only block that drives the RAM address. Its output feeds the OMP correlation/projection datapath.

Parameters:
ADDR_W, 5, RAM address width (depth 2^ADDR_W = 32 rows)
ROW_W, 1152, RAM data width
WORD_W, 32, stream word width; ROW_W must be a multiple of WORD_W
WORDS_PER_ROW, 36, ROW_W/WORD_W
RD_LAT, 1, RAM read latency in clocks (address sampled to douta valid); legal range 1..4

Ports:
clka  in  1  system clock; also clocks the RAM
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle command; sampled only in IDLE
first_row  in  ADDR_W  first row to fetch; sampled with start
num_rows  in  ADDR_W+1  row count; 0 = no-op; values >32 clamp to 32
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse at command completion
ram_addr  out  ADDR_W  registered address to the RAM addra
ram_dout  in  ROW_W  RAM douta
m_data  out  WORD_W  stream word
m_valid  out  1  stream valid
m_ready  in  1  stream ready; a transfer occurs when m_valid && m_ready at a rising edge
m_word_idx  out  6  index of the current word in its row, 0..35
m_row_idx  out  ADDR_W  RAM row of the current word
m_last_word  out  1  high with word 35 of each row
m_last_row  out  1  high for every word of the final row

Behaviour:
- Reset: all outputs are 0, state = IDLE, row counter = 0, and the row shift register is cleared. Reset mid-command aborts immediately: no done pulse, and m_valid is 0 after the reset edge.
- FSM states: IDLE, FETCH, WAIT, STREAM, FIN.
- IDLE to FETCH: on start with clamped num_rows != 0. At that edge: ram_addr <= first_row, busy <= 1, rows_left <= clamped num_rows.
- IDLE to FIN: on start with num_rows == 0. busy pulses for 1 cycle and done pulses the following cycle; no stream activity occurs.
- FETCH/WAIT: count RD_LAT+1 edges from the address update. On the last of these edges, latch ram_dout into the row register, set m_valid <= 1 and m_word_idx <= 0, then go to STREAM.
  - With RD_LAT=1, m_valid first rises after edge 2, counting the start edge as edge 0.
- STREAM: m_data = row_reg[WORD_W*k +: WORD_W] for k = m_word_idx, LSB word first. Each transfer increments m_word_idx.
  - While m_valid && !m_ready, m_data and all sideband outputs hold stable. m_valid never drops without a transfer.
- Row end: on the transfer of word 35, m_valid <= 0 and rows_left decrements.
  - If rows remain: ram_addr <= ram_addr + 1 (mod 32, so 31 wraps to 0), then return to WAIT. m_valid stays low for exactly RD_LAT+1 cycles between rows.
  - If this was the final row: go to FIN.
- FIN: done = 1 for one cycle, busy deasserts in the same cycle, then return to IDLE. A new start is accepted on the cycle after done.
- start in any state other than IDLE is ignored; first_row and num_rows are not re-sampled.
- m_row_idx equals the address of the row currently held in row_reg. m_last_row = (rows_left == 1) while in STREAM.
- ram_addr holds its last value when idle. Only rows first_row .. first_row+n-1 (mod 32) are addressed.

Test Plan:
- RAM model: word k of row r = {16'hA5A5, r[7:0], k[7:0]}.
1. Reset, then start with first_row=0, num_rows=1, m_ready=1 -> m_valid rises after edge 2; 36 back-to-back words 0xA5A50000..0xA5A50023; m_last_word and m_last_row on the 36th word; done pulses 1 cycle after the last transfer; busy=0 with done.
2. first_row=30, num_rows=4, m_ready=1 -> m_row_idx sequence 30, 31, 0, 1 (wrap); 144 transfers; 2-cycle m_valid gap between rows; m_last_row only during row 1.
3. first_row=5, num_rows=1, m_ready pattern 1,0,0,0,0,0,1,0,1... -> m_data and indices hold stable while stalled; exactly 36 transfers with no duplicates or drops; order 0x..0500..0x..0523.
4. num_rows=0 -> done the cycle after busy, m_valid never 1. num_rows=40 -> 32 rows streamed starting at first_row, 1152 transfers.
5. Second start during a busy command -> ignored and the first command completes unchanged. Assert rst at word 10 of row 2 -> all outputs 0 after that edge, no done pulse; a fresh start with first_row=7, num_rows=1 streams row 7 correctly.
6. RD_LAT=2 build, num_rows=2 -> first m_valid after edge 3; 3-cycle inter-row gap; data correct.
